div_share_ctrl: RTL and testbench
=================================

// Module: div_share_ctrl
// PURPOSE
//  Shares one iterative restoring divider (shift-subtract, one quotient bit per clock) between NREQ requesters.
//  Round-robin arbitration; valid/ready handshake on each request port and on the single response port.
//  Sits between the client blocks and the division datapath; replaces the per-client combinational dividers.
// PARAMETERS
//  NREQ  4   number of requester ports (2..8)
//  W     16  operand, quotient and remainder width
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  req_valid  in   NREQ    request i has an operand pair
//  req_ready  out  NREQ    one-hot grant; request i accepted on the edge where valid&ready
//  req_x      in   NREQ*W  dividends, slice i = [i*W +: W]
//  req_y      in   NREQ*W  divisors, same packing
//  rsp_valid  out  1       result available
//  rsp_ready  in   1       consumer takes the result
//  rsp_id     out  clog2(NREQ)  index of the requester that owns the result
//  rsp_quot   out  W       quotient
//  rsp_rem    out  W       remainder
//  busy       out  1       high in every state except IDLE
//  rsp_err    out  1       only when DIV_BYZERO_ERR_EN is defined
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, rr_ptr=0, all outputs 0.
//  FSM states: IDLE -> ITER -> DONE -> IDLE.
//  IDLE:
//   - req_ready is combinational: one-hot on the first valid index at or after rr_ptr, searching with wrap.
//   - All-zero req_ready when no request is valid.
//   - On the accept edge: latch x into q, y into m, temp=0, cnt=0, id=grant; rr_ptr=(grant+1)%NREQ; go to ITER.
//  ITER, one step per edge:
//   - {temp,q} <<= 1.
//   - If temp >= m: temp -= m and q[0] = 1.
//   - cnt++.
//   - After step W (cnt == W-1) go to DONE.
//   - temp is W+1 bits wide so the compare cannot overflow.
//  DONE:
//   - rsp_valid = 1; rsp_quot, rsp_rem and rsp_id are held stable until rsp_valid&&rsp_ready.
//   - After the response handshake, go to IDLE.
//  Latency: rsp_valid rises W edges after the accept edge (16 for W=16).
//   - Minimum spacing between accepts is W+2 cycles.
//  Backpressure: any number of stall cycles in DONE; no result is ever dropped or overwritten.
//  req_ready is 0 outside IDLE. Requesters hold valid and operands until granted.
//  A change of req_x/req_y after acceptance has no effect on the operation in flight.
//  Simultaneous valids are served in rr order; no requester waits more than NREQ-1 grants.
//  Reset mid-operation: abort immediately to reset values; the partial result is discarded.
//  y==0 without the macro runs the normal W steps: quotient all-ones, remainder = x.
// CONFIGURATION
//  DIV_BYZERO_ERR_EN defined:
//   - If the latched y==0, skip ITER and go straight to DONE.
//   - rsp_quot={W{1'b1}}, rsp_rem=x, rsp_err=1; latency 1.
//   - rsp_err=0 for every other result.
//  DIV_BYZERO_ERR_EN undefined: no rsp_err port; y==0 behaves as stated under BEHAVIOUR.
// STRUCTURE
//  Package div_pkg:
//   - state enum {IDLE, ITER, DONE}.
//   - DIV_W default.
//   - function rr_pick(valid, ptr) returning a one-hot grant.
//  Sub-module div_iter_core: the temp/q/m registers and the one-step shift-subtract.
//   - Inputs: load, step, x, y.
//   - Outputs: quot, rem.
//  The controller keeps the FSM, counter, arbiter and id register.
// TESTING
//  1. Port0 x=10,y=2 -> rsp_quot=5, rsp_rem=0, rsp_id=0, rsp_valid 16 cycles after accept.
//  2. Port1 x=10,y=11 -> quot=0, rem=10, rsp_id=1.
//  3. All 4 ports valid at once, rr_ptr=0 -> grant order 0,1,2,3.
//     - Then port 2 revalid along with port 0 -> port 0 (ptr wrapped to 0).
//  4. x=65535,y=1 with rsp_ready=0 for 5 cycles -> outputs stable through the stall.
//     - quot=65535, rem=0 after the handshake; busy drops the next cycle.
//  5. x=1234,y=0 -> quot=0xFFFF, rem=1234.
//     - Macro undefined: latency 16.
//     - Macro defined: latency 1 and rsp_err=1.
//  6. rst_n low at ITER step 7 -> all outputs 0 asynchronously.
//     - After release, a new request x=100,y=7 -> quot=14, rem=2.
//  Scoreboard compares every response with x/y and x%y for 2000 random operands with random rsp_ready.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared types and helpers for the shared restoring-divider block.
// Holds the controller state encoding, the default data width and the
// round-robin pick used by the request arbiter.
package div_pkg;

    localparam int DIV_W   = 16;
    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } state_t;

    // Returns a one-hot grant on the first valid index at or after ptr,
    // searching upward with wrap over the nreq active requesters.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [2:0]         ptr,
        input int                 nreq
    );
        logic [MAX_REQ-1:0] grant;
        logic               found;
        int                 idx;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx = (int'({29'd0, ptr}) + i) % nreq;
            if (!found && (i < nreq) && valid[idx[2:0]]) begin
                grant[idx[2:0]] = 1'b1;
                found           = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/div_iter_core.sv
// div_iter_core: restoring-divider datapath, one quotient bit per step.
// The partial remainder, the dividend/quotient shift register and the
// divisor live here; the controller only says when to load and when to step.
module div_iter_core #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] quot,
    output logic [W-1:0] rem
);

    // The stored remainder always ends a step below the divisor, so W bits
    // hold it; the shifted trial value needs the extra bit for the compare.
    logic [W-1:0] r_temp;
    logic [W-1:0] r_q;
    logic [W-1:0] r_m;
    logic [W:0]   w_shift;
    logic         w_ge;
    logic [W-1:0] w_next_temp;

    // Trial subtract for the next step of {temp,q} <<= 1
    always_comb begin
        // NOTE: every combinational output gets a value on every path so no latch is inferred.
        w_shift     = {r_temp, r_q[W-1]};
        w_ge        = (w_shift >= {1'b0, r_m});
        w_next_temp = w_ge ? W'(w_shift - {1'b0, r_m}) : w_shift[W-1:0];
    end

    // Datapath registers: load operands, then shift-subtract once per step
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: these are plain registers, not a memory, so they reset; an aborted division then reads as zero.
        if (!rst_n) begin
            r_temp <= '0;
            r_q    <= '0;
            r_m    <= '0;
        end else if (load) begin
            r_temp <= '0;
            r_q    <= x;
            r_m    <= y;
        end else if (step) begin
            r_temp <= w_next_temp;
            r_q    <= {r_q[W-2:0], w_ge};
        end
    end

    assign quot = r_q;
    assign rem  = r_temp;

endmodule

// File: rtl/div_share_ctrl.sv
// div_share_ctrl: shares one iterative divider between NREQ requesters with
// round-robin arbitration and valid/ready handshakes on both sides.
// Optional macro DIV_BYZERO_ERR_EN: a zero divisor skips the iterations,
// answers after one cycle with quotient all-ones, remainder = dividend, and
// raises rsp_err.
module div_share_ctrl
    import div_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int W    = DIV_W,
    localparam int IDW  = $clog2(NREQ),
    localparam int CW   = $clog2(W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_x,
    input  logic [NREQ*W-1:0] req_y,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_quot,
    output logic [W-1:0]      rsp_rem,
    output logic              busy
`ifdef DIV_BYZERO_ERR_EN
    ,
    output logic              rsp_err
`endif
);

    state_t          r_state;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_id;
    logic [CW-1:0]   r_cnt;
    logic            r_rsp_valid;
    logic            r_busy;
`ifdef DIV_BYZERO_ERR_EN
    logic            r_byz;
    logic            r_err;
`endif

    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_gidx;
    logic [IDW-1:0]  w_next_ptr;
    logic [W-1:0]    w_gx;
    logic [W-1:0]    w_gy;
    logic [W-1:0]    w_quot;
    logic [W-1:0]    w_rem;
    logic            w_accept;
    logic            w_step;

    // Round-robin grant (IDLE only) and mux of the granted operands
    always_comb begin
        w_grant = (r_state == IDLE) ? NREQ'(rr_pick(MAX_REQ'(req_valid), 3'(r_ptr), NREQ)) : '0;
        w_gidx  = '0;
        w_gx    = '0;
        w_gy    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_gidx = IDW'(i);
                w_gx   = req_x[i*W +: W];
                w_gy   = req_y[i*W +: W];
            end
        end
        w_accept   = |w_grant;
        w_next_ptr = (w_gidx == IDW'(NREQ - 1)) ? '0 : w_gidx + IDW'(1);
`ifdef DIV_BYZERO_ERR_EN
        w_step     = (r_state == ITER) && !r_byz;
`else
        w_step     = (r_state == ITER);
`endif
    end

    div_iter_core #(.W(W)) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_accept),
        .step  (w_step),
        .x     (w_gx),
        .y     (w_gy),
        .quot  (w_quot),
        .rem   (w_rem)
    );

    // Controller FSM: accept a request, count W steps, hold the result until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_id        <= '0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef DIV_BYZERO_ERR_EN
            r_byz       <= 1'b0;
            r_err       <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_id    <= w_gidx;
                        r_ptr   <= w_next_ptr;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ITER;
`ifdef DIV_BYZERO_ERR_EN
                        r_byz   <= (w_gy == '0);
`endif
                    end
                end
                ITER: begin
`ifdef DIV_BYZERO_ERR_EN
                    if (r_byz) begin
                        r_state     <= DONE;
                        r_rsp_valid <= 1'b1;
                        r_err       <= 1'b1;
                    end else
`endif
                    begin
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == CW'(W - 1)) begin
                            r_state     <= DONE;
                            r_rsp_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
`ifdef DIV_BYZERO_ERR_EN
                        r_err       <= 1'b0;
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = w_grant;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_id;
    assign busy      = r_busy;
`ifdef DIV_BYZERO_ERR_EN
    // A zero divisor never steps the core, so its q register still holds the dividend.
    assign rsp_quot  = r_err ? '1 : w_quot;
    assign rsp_rem   = r_err ? w_quot : w_rem;
    assign rsp_err   = r_err;
`else
    assign rsp_quot  = w_quot;
    assign rsp_rem   = w_rem;
`endif

endmodule

// File: tb/tb_div_share_ctrl.sv
// tb_div_share_ctrl: directed scenarios plus a randomized scoreboard run
// for the shared divider. Expected results come from integer / and %, and
// grant order from a plain round-robin search over the pending requesters.
module tb_div_share_ctrl;

    localparam int NREQ = 4;
    localparam int W    = 16;
    localparam int IDW  = 2;
    localparam int NOPS = 2000;
`ifdef DIV_BYZERO_ERR_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = W;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_x = '0;
    logic [NREQ*W-1:0] req_y = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_quot;
    logic [W-1:0]      rsp_rem;
    logic              busy;
`ifdef DIV_BYZERO_ERR_EN
    logic              rsp_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int model_ptr = 0;

    typedef struct {
        int         id;
        logic [W-1:0] x;
        logic [W-1:0] y;
    } op_t;

    always #5 clk = ~clk;

    div_share_ctrl #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_quot  (rsp_quot),
        .rsp_rem   (rsp_rem),
        .busy      (busy)
`ifdef DIV_BYZERO_ERR_EN
        ,
        .rsp_err   (rsp_err)
`endif
    );

    // Reference rules
    function automatic int model_pick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] exp_q(input logic [W-1:0] x, input logic [W-1:0] y);
        return (y == 0) ? {W{1'b1}} : x / y;
    endfunction

    function automatic logic [W-1:0] exp_r(input logic [W-1:0] x, input logic [W-1:0] y);
        return (y == 0) ? x : x % y;
    endfunction

    // Stimulus helpers (no checking inside)
    task automatic wait_rsp(output int lat, output logic to);
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 200) begin
            @(negedge clk); #1;
            lat++;
        end
        to = (rsp_valid !== 1'b1);
    endtask

    task automatic wait_ready(output logic to);
        int w;
        w = 0;
        while (req_ready === '0 && w < 200) begin
            @(negedge clk); #1;
            w++;
        end
        to = (req_ready === '0);
    endtask

    // Present one request on a port, let it be accepted, scramble the port's
    // operands afterwards, and wait for rsp_valid (lat = edges after accept).
    task automatic issue(input int port, input logic [W-1:0] x, input logic [W-1:0] y,
                         output int lat, output logic to);
        logic to_r;
        @(negedge clk);
        req_valid[port]       = 1'b1;
        req_x[port*W +: W]    = x;
        req_y[port*W +: W]    = y;
        #1;
        wait_ready(to_r);
        to = to_r;
        lat = 0;
        if (to_r) begin
            req_valid[port] = 1'b0;
        end else begin
            @(posedge clk);
            model_ptr = (port + 1) % NREQ;
            @(negedge clk);
            req_valid[port]    = 1'b0;
            req_x[port*W +: W] = W'($urandom);
            req_y[port*W +: W] = W'($urandom);
            #1;
            wait_rsp(lat, to);
        end
    endtask

    task automatic take();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 0;
        #1;
    endtask

    // Scenarios
    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if ({rsp_valid, busy, rsp_id, rsp_quot, rsp_rem, req_ready} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b b=%b id=%0d q=%0d r=%0d rdy=%b, want all 0",
                     rsp_valid, busy, rsp_id, rsp_quot, rsp_rem, req_ready);
        end
`ifdef DIV_BYZERO_ERR_EN
        n_checks++;
        if (rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err: got %b want 0", rsp_err);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 0;
    endtask

    task automatic test_basic();
        int   lat;
        logic to;
        issue(0, 16'd10, 16'd2, lat, to);
        n_checks++;
        if (to || lat != W) begin
            n_fail++;
            $display("FAIL basic0_latency: got %0d (timeout=%b) want %0d", lat, to, W);
        end
        n_checks++;
        if ({rsp_quot, rsp_rem, rsp_id} !== {16'd5, 16'd0, 2'd0}) begin
            n_fail++;
            $display("FAIL basic0_result: got q=%0d r=%0d id=%0d want q=5 r=0 id=0", rsp_quot, rsp_rem, rsp_id);
        end
`ifdef DIV_BYZERO_ERR_EN
        n_checks++;
        if (rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL basic0_err: got %b want 0", rsp_err);
        end
`endif
        take();
        issue(1, 16'd10, 16'd11, lat, to);
        n_checks++;
        if (to || {rsp_quot, rsp_rem, rsp_id} !== {16'd0, 16'd10, 2'd1}) begin
            n_fail++;
            $display("FAIL basic1_result: got q=%0d r=%0d id=%0d (timeout=%b) want q=0 r=10 id=1",
                     rsp_quot, rsp_rem, rsp_id, to);
        end
        take();
    endtask

    task automatic test_round_robin();
        int              order[6] = '{0, 1, 2, 3, 0, 2};
        logic [W-1:0]    ox[NREQ];
        logic [W-1:0]    oy[NREQ];
        logic [NREQ-1:0] e;
        int              g;
        int              lat;
        logic            to;
        do_reset();
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            ox[i] = W'(1000 + i * 77);
            oy[i] = W'(i + 3);
            req_valid[i]     = 1'b1;
            req_x[i*W +: W]  = ox[i];
            req_y[i*W +: W]  = oy[i];
        end
        #1;
        for (int k = 0; k < 6; k++) begin
            if (k == 4) begin
                // Port 2 comes back together with port 0; pointer has wrapped to 0.
                @(negedge clk);
                ox[0] = 16'd500; oy[0] = 16'd9;
                ox[2] = 16'd777; oy[2] = 16'd5;
                req_valid[0] = 1'b1; req_x[0 +: W] = ox[0]; req_y[0 +: W] = oy[0];
                req_valid[2] = 1'b1; req_x[2*W +: W] = ox[2]; req_y[2*W +: W] = oy[2];
                #1;
            end
            wait_ready(to);
            g = order[k];
            e = '0;
            e[g] = 1'b1;
            n_checks++;
            if (to || req_ready !== e) begin
                n_fail++;
                $display("FAIL rr_grant_%0d: got %b (timeout=%b) want %b", k, req_ready, to, e);
            end
            @(posedge clk);
            model_ptr = (g + 1) % NREQ;
            @(negedge clk);
            req_valid[g] = 1'b0;
            #1;
            if (req_valid != '0) begin
                n_checks++;
                if (req_ready !== '0) begin
                    n_fail++;
                    $display("FAIL rr_busy_ready_%0d: got %b want 0000", k, req_ready);
                end
            end
            wait_rsp(lat, to);
            n_checks++;
            if (to || rsp_id !== IDW'(g) || rsp_quot !== exp_q(ox[g], oy[g]) || rsp_rem !== exp_r(ox[g], oy[g])) begin
                n_fail++;
                $display("FAIL rr_result_%0d: got id=%0d q=%0d r=%0d (timeout=%b) want id=%0d q=%0d r=%0d",
                         k, rsp_id, rsp_quot, rsp_rem, to, g, exp_q(ox[g], oy[g]), exp_r(ox[g], oy[g]));
            end
            take();
        end
    endtask

    task automatic test_backpressure();
        int           lat;
        logic         to;
        logic [W-1:0] q0;
        logic [W-1:0] r0;
        logic [IDW-1:0] id0;
        issue(3, 16'd65535, 16'd1, lat, to);
        q0 = rsp_quot; r0 = rsp_rem; id0 = rsp_id;
        n_checks++;
        if (to || lat != W) begin
            n_fail++;
            $display("FAIL stall_latency: got %0d (timeout=%b) want %0d", lat, to, W);
        end
        for (int s = 0; s < 5; s++) begin
            @(negedge clk); #1;
            n_checks++;
            if (rsp_valid !== 1'b1 || busy !== 1'b1 || rsp_quot !== q0 || rsp_rem !== r0 || rsp_id !== id0) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: got v=%b b=%b q=%0d r=%0d id=%0d want v=1 b=1 q=%0d r=%0d id=%0d",
                         s, rsp_valid, busy, rsp_quot, rsp_rem, rsp_id, q0, r0, id0);
            end
        end
        n_checks++;
        if ({rsp_quot, rsp_rem, rsp_id} !== {16'd65535, 16'd0, 2'd3}) begin
            n_fail++;
            $display("FAIL stall_result: got q=%0d r=%0d id=%0d want q=65535 r=0 id=3", rsp_quot, rsp_rem, rsp_id);
        end
        take();
        n_checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release: got busy=%b valid=%b want 0 0", busy, rsp_valid);
        end
    endtask

    task automatic test_div_zero();
        int   lat;
        logic to;
        issue(1, 16'd1234, 16'd0, lat, to);
        n_checks++;
        if (to || lat != ZLAT) begin
            n_fail++;
            $display("FAIL divzero_latency: got %0d (timeout=%b) want %0d", lat, to, ZLAT);
        end
        n_checks++;
        if ({rsp_quot, rsp_rem, rsp_id} !== {16'hFFFF, 16'd1234, 2'd1}) begin
            n_fail++;
            $display("FAIL divzero_result: got q=%h r=%0d id=%0d want q=ffff r=1234 id=1", rsp_quot, rsp_rem, rsp_id);
        end
`ifdef DIV_BYZERO_ERR_EN
        n_checks++;
        if (rsp_err !== 1'b1) begin
            n_fail++;
            $display("FAIL divzero_err: got %b want 1", rsp_err);
        end
`endif
        take();
    endtask

    task automatic test_reset_mid();
        int   lat;
        logic to;
        @(negedge clk);
        req_valid[2] = 1'b1; req_x[2*W +: W] = 16'd5000; req_y[2*W +: W] = 16'd3;
        #1;
        wait_ready(to);
        @(posedge clk);
        @(negedge clk);
        req_valid[2] = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        n_checks++;
        if (to || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_pre_busy: got %b (timeout=%b) want 1", busy, to);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rsp_valid, busy, rsp_id, rsp_quot, rsp_rem, req_ready} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got v=%b b=%b id=%0d q=%0d r=%0d rdy=%b want all 0",
                     rsp_valid, busy, rsp_id, rsp_quot, rsp_rem, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 0;
        issue(3, 16'd100, 16'd7, lat, to);
        n_checks++;
        if (to || lat != W || {rsp_quot, rsp_rem, rsp_id} !== {16'd14, 16'd2, 2'd3}) begin
            n_fail++;
            $display("FAIL midreset_after: got q=%0d r=%0d id=%0d lat=%0d (timeout=%b) want q=14 r=2 id=3 lat=%0d",
                     rsp_quot, rsp_rem, rsp_id, lat, to, W);
        end
        take();
    endtask

    task automatic test_random();
        op_t             sb[$];
        op_t             op;
        logic [NREQ-1:0] pend;
        logic [NREQ-1:0] exp_rdy;
        logic [W-1:0]    vx[NREQ];
        logic [W-1:0]    vy[NREQ];
        logic            free;
        int              issued;
        int              done;
        int              cyc;
        int              g;
        pend = '0; free = 1'b1; issued = 0; done = 0; cyc = 0;
        while ((issued < NOPS || sb.size() != 0) && cyc < 80000) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && (issued + $countones(pend)) < NOPS && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    vx[i]   = W'($urandom);
                    case ($urandom_range(0, 7))
                        0:       vy[i] = '0;
                        1, 2:    vy[i] = W'($urandom_range(1, 15));
                        default: vy[i] = W'($urandom);
                    endcase
                end
                req_x[i*W +: W] = pend[i] ? vx[i] : W'($urandom);
                req_y[i*W +: W] = pend[i] ? vy[i] : W'($urandom);
            end
            req_valid = pend;
            rsp_ready = ($urandom_range(0, 1) == 1);
            #1;
            exp_rdy = '0;
            g = -1;
            if (free) begin
                g = model_pick(pend, model_ptr);
                if (g >= 0) exp_rdy[g] = 1'b1;
            end
            n_checks++;
            if (req_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL rand_grant cyc %0d: got %b want %b", cyc, req_ready, exp_rdy);
            end
            if (g >= 0) begin
                sb.push_back('{g, vx[g], vy[g]});
                pend[g]   = 1'b0;
                model_ptr = (g + 1) % NREQ;
                issued++;
                free = 1'b0;
            end
            if (rsp_valid === 1'b1 && rsp_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_spurious cyc %0d: got rsp_valid=1 want 0", cyc);
                end else begin
                    op = sb.pop_front();
                    if (rsp_id !== IDW'(op.id) || rsp_quot !== exp_q(op.x, op.y) || rsp_rem !== exp_r(op.x, op.y)) begin
                        n_fail++;
                        $display("FAIL rand_result #%0d x=%0d y=%0d: got id=%0d q=%0d r=%0d want id=%0d q=%0d r=%0d",
                                 done, op.x, op.y, rsp_id, rsp_quot, rsp_rem, op.id, exp_q(op.x, op.y), exp_r(op.x, op.y));
                    end
`ifdef DIV_BYZERO_ERR_EN
                    n_checks++;
                    if (rsp_err !== (op.y == '0)) begin
                        n_fail++;
                        $display("FAIL rand_err #%0d: got %b want %b", done, rsp_err, (op.y == '0));
                    end
`endif
                    done++;
                    free = 1'b1;
                end
            end
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        n_checks++;
        if (done != NOPS) begin
            n_fail++;
            $display("FAIL rand_complete: got %0d responses want %0d", done, NOPS);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_backpressure();
        test_div_zero();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
